// File: rtl/reg_bank.sv
// Datapath register bank: C-bus writes, B-bus read mux, PC/AR/RC/CC increments, IR load, RC==LIM flag.
// Optional macro REG_BANK_SAT_INC_EN makes increments saturate at all-ones instead of wrapping.
module reg_bank #(
  parameter int                 DATA_W  = 16,
  parameter logic [DATA_W-1:0]  LIM_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        C_Bus_CU,
  input  logic [4:0]        B_Bus_CU,
  input  logic [2:0]        Reg_Inc_CU,
  input  logic              IR_Load,
  input  logic [DATA_W-1:0] c_bus_in,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] b_bus_out,
  output logic [DATA_W-1:0] ar_out,
  output logic [7:0]        IR_Input,
  output logic              flag
);

  localparam logic [4:0] SEL_PC  = 5'd1;
  localparam logic [4:0] SEL_AR  = 5'd2;
  localparam logic [4:0] SEL_DR  = 5'd3;
  localparam logic [4:0] SEL_TR  = 5'd4;
  localparam logic [4:0] SEL_AC  = 5'd5;
  localparam logic [4:0] SEL_R1  = 5'd6;
  localparam logic [4:0] SEL_R2  = 5'd7;
  localparam logic [4:0] SEL_RC  = 5'd8;
  localparam logic [4:0] SEL_CC  = 5'd9;
  localparam logic [4:0] SEL_LIM = 5'd10;
  localparam logic [4:0] SEL_IR  = 5'd11;
  localparam logic [4:0] SEL_MEM = 5'd12;

  localparam logic [2:0] INC_PC  = 3'd1;
  localparam logic [2:0] INC_AR  = 3'd2;
  localparam logic [2:0] INC_RC  = 3'd3;
  localparam logic [2:0] INC_CC  = 3'd4;
  localparam logic [2:0] INC_ROW = 3'd5;

  logic [DATA_W-1:0] pc_q, ar_q, dr_q, tr_q, ac_q, r1_q, r2_q, rc_q, cc_q, lim_q;
  logic [DATA_W-1:0] pc_d, ar_d, dr_d, tr_d, ac_d, r1_d, r2_d, rc_d, cc_d, lim_d;
  logic [7:0]        ir_q, ir_d;

  function automatic logic [DATA_W-1:0] inc(input logic [DATA_W-1:0] v);
`ifdef REG_BANK_SAT_INC_EN
    inc = (v == '1) ? v : v + 1'b1;
`else
    inc = v + 1'b1;
`endif
  endfunction

  always_comb begin
    pc_d  = pc_q;
    ar_d  = ar_q;
    dr_d  = dr_q;
    tr_d  = tr_q;
    ac_d  = ac_q;
    r1_d  = r1_q;
    r2_d  = r2_q;
    rc_d  = rc_q;
    cc_d  = cc_q;
    lim_d = lim_q;
    ir_d  = ir_q;

    case (Reg_Inc_CU)
      INC_PC:  pc_d = inc(pc_q);
      INC_AR:  ar_d = inc(ar_q);
      INC_RC:  rc_d = inc(rc_q);
      INC_CC:  cc_d = inc(cc_q);
      INC_ROW: begin
        rc_d = inc(rc_q);
        cc_d = '0;
      end
      default: ;
    endcase

    // C write is applied after increments so it overrides them on collision
    case (C_Bus_CU)
      SEL_PC:  pc_d  = c_bus_in;
      SEL_AR:  ar_d  = c_bus_in;
      SEL_DR:  dr_d  = c_bus_in;
      SEL_TR:  tr_d  = c_bus_in;
      SEL_AC:  ac_d  = c_bus_in;
      SEL_R1:  r1_d  = c_bus_in;
      SEL_R2:  r2_d  = c_bus_in;
      SEL_RC:  rc_d  = c_bus_in;
      SEL_CC:  cc_d  = c_bus_in;
      SEL_LIM: lim_d = c_bus_in;
      default: ;
    endcase

    if (IR_Load) ir_d = mem_data_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      ar_q  <= '0;
      dr_q  <= '0;
      tr_q  <= '0;
      ac_q  <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      rc_q  <= '0;
      cc_q  <= '0;
      lim_q <= LIM_RST;
      ir_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      ar_q  <= ar_d;
      dr_q  <= dr_d;
      tr_q  <= tr_d;
      ac_q  <= ac_d;
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      rc_q  <= rc_d;
      cc_q  <= cc_d;
      lim_q <= lim_d;
      ir_q  <= ir_d;
    end
  end

  always_comb begin
    b_bus_out = '0;
    case (B_Bus_CU)
      SEL_PC:  b_bus_out = pc_q;
      SEL_AR:  b_bus_out = ar_q;
      SEL_DR:  b_bus_out = dr_q;
      SEL_TR:  b_bus_out = tr_q;
      SEL_AC:  b_bus_out = ac_q;
      SEL_R1:  b_bus_out = r1_q;
      SEL_R2:  b_bus_out = r2_q;
      SEL_RC:  b_bus_out = rc_q;
      SEL_CC:  b_bus_out = cc_q;
      SEL_LIM: b_bus_out = lim_q;
      SEL_IR:  b_bus_out = {{(DATA_W-8){1'b0}}, ir_q};
      SEL_MEM: b_bus_out = mem_data_in;
      default: b_bus_out = '0;
    endcase
  end

  assign ar_out   = ar_q;
  assign IR_Input = ir_q;
  assign flag     = (rc_q == lim_q);

endmodule
